// File: rtl/io_input.sv
// Board-input conditioner: two-flop synchronisers plus per-bit debounce for slide switches
// and push keys, with registered one-cycle press/release pulses for the keys.
module io_input #(
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_KEY-1:0] key_in,
    output logic [NUM_SW-1:0]  sw_out,
    output logic [NUM_KEY-1:0] key_level,
    output logic [NUM_KEY-1:0] key_press,
    output logic [NUM_KEY-1:0] key_release
);

    localparam int NB = NUM_SW + NUM_KEY;
    localparam logic [NUM_KEY-1:0] KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? {NUM_KEY{1'b1}} : {NUM_KEY{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_SW-1:0]  sw_meta_q, sw_sync_q;
    logic [NUM_KEY-1:0] key_meta_q, key_sync_q;
    logic [NUM_KEY-1:0] key_sync_act;
    logic [NB-1:0]      sync_s;

    logic [NB-1:0]      stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q [NB];
    logic [CNT_W-1:0]   cnt_d [NB];
    logic [NUM_KEY-1:0] press_q, press_d;
    logic [NUM_KEY-1:0] release_q, release_d;

    // Key synchronisers reset to the pad's released level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= KEY_IDLE;
            key_sync_q <= KEY_IDLE;
        end else begin
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= key_in;
            key_sync_q <= key_meta_q;
        end
    end

    assign key_sync_act = (KEY_ACTIVE_LOW != 0) ? ~key_sync_q : key_sync_q;
    assign sync_s       = {key_sync_act, sw_sync_q};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        // Pulses are registered alongside the level, so they coincide with its first new cycle.
        press_d   =  stable_d[NB-1:NUM_SW] & ~stable_q[NB-1:NUM_SW];
        release_d = ~stable_d[NB-1:NUM_SW] &  stable_q[NB-1:NUM_SW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_out      = stable_q[NUM_SW-1:0];
    assign key_level   = stable_q[NB-1:NUM_SW];
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule
